// File: rtl/fb_scanout.sv
// fb_scanout: VGA scan-out stage for an RGB444 frame-buffer bRAM (read port B).
// Generates 640x480@60 timing, drives the registered bRAM read address, and
// registers the read data out to the DAC pins with active-low hsync/vsync.
// Scanning starts and stops only on frame boundaries.
// Ports: clk, rstn (async, active low), pix_en (pixel tick), en (scan request),
//   addrb/doutb (bRAM port B, 1-clk read latency), vga_r/g/b, vga_hs, vga_vs,
//   frame_start (pulse at counter origin), scanning (FSM in SCAN).
// Optional: `define TEST_PATTERN_EN adds input pat_sel selecting 8 colour bars.
module fb_scanout #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int ADDR_W   = 19,
  parameter int DATA_W   = 12
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              pix_en,
  input  logic              en,
`ifdef TEST_PATTERN_EN
  input  logic              pat_sel,
`endif
  output logic [ADDR_W-1:0] addrb,
  input  logic [DATA_W-1:0] doutb,
  output logic [3:0]        vga_r,
  output logic [3:0]        vga_g,
  output logic [3:0]        vga_b,
  output logic              vga_hs,
  output logic              vga_vs,
  output logic              frame_start,
  output logic              scanning
);
  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int CW = $clog2(HT > VT ? HT : VT);
  localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] H_S0   = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] H_S1   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] H_LAST = CW'(HT - 1);
  localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] V_S0   = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] V_S1   = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0] V_LAST = CW'(VT - 1);
  localparam logic [ADDR_W-1:0] A_LAST = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);
  typedef enum logic {IDLE, SCAN} state_t;
  state_t state;
  logic [CW-1:0] h_cnt, v_cnt;
  logic h_end, v_end, frame_end, origin, active, hs_raw, vs_raw;
  logic act_d1, hs_d1, vs_d1, tick_q;
  logic [DATA_W-1:0] d_tick, src;
  logic [11:0] pixel;
  always_comb begin
    h_end     = h_cnt == H_LAST;
    v_end     = v_cnt == V_LAST;
    frame_end = h_end && v_end;
    origin    = h_cnt == '0 && v_cnt == '0;
    active    = h_cnt < H_ACT && v_cnt < V_ACT;
    hs_raw    = !(h_cnt >= H_S0 && h_cnt < H_S1);
    vs_raw    = !(v_cnt >= V_S0 && v_cnt < V_S1);
  end
  // Data for the address loaded two ticks ago: with back-to-back ticks it is
  // still on doutb; with sparse ticks doutb has already moved on to the next
  // address, so use the copy taken at the previous tick (addrb was held then).
  // pix_en is therefore either tied high or never high on consecutive clks.
  assign src = tick_q ? doutb : d_tick;
`ifdef TEST_PATTERN_EN
  logic [CW-1:0] h_d1;
  logic [2:0] bar;
  assign bar   = 3'(h_d1 / CW'(H_ACTIVE / 8));
  assign pixel = pat_sel ? {{4{bar[2]}}, {4{bar[1]}}, {4{bar[0]}}} : src[11:0];
`else
  assign pixel = src[11:0];
`endif
  assign scanning = state == SCAN;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      addrb       <= '0;
      state       <= IDLE;
      act_d1      <= 1'b0;
      hs_d1       <= 1'b1;
      vs_d1       <= 1'b1;
      tick_q      <= 1'b0;
      d_tick      <= '0;
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      frame_start <= 1'b0;
`ifdef TEST_PATTERN_EN
      h_d1        <= '0;
`endif
    end else begin
      tick_q      <= pix_en;
      frame_start <= pix_en && origin;
      if (pix_en) begin
        h_cnt  <= h_end ? '0 : h_cnt + CW'(1);
        v_cnt  <= !h_end ? v_cnt : v_end ? '0 : v_cnt + CW'(1);
        // Running address: always points at the next pixel to be fetched.
        addrb  <= (frame_end || (active && addrb == A_LAST)) ? '0 :
                  active ? addrb + ADDR_W'(1) : addrb;
        act_d1 <= active;
        hs_d1  <= hs_raw;
        vs_d1  <= vs_raw;
        d_tick <= doutb;
        vga_hs <= hs_d1;
        vga_vs <= vs_d1;
        {vga_r, vga_g, vga_b} <= (state == SCAN && act_d1) ? pixel : 12'h000;
        state  <= state == IDLE ? ((origin && en) ? SCAN : IDLE) :
                  ((frame_end && !en) ? IDLE : SCAN);
`ifdef TEST_PATTERN_EN
        h_d1   <= h_cnt;
`endif
      end
    end
  end
endmodule

// File: tb/tb_fb_scanout.sv
// tb_fb_scanout: directed checks of fb_scanout on a reduced 24x12 timing (16x8 visible).
module tb_fb_scanout;
  localparam int HA = 16, HT = 24, VA = 8, VT = 12, FT = HT * VT, PIX = HA * VA;
  logic clk = 1'b0, rstn = 1'b0, pix_en = 1'b0, en = 1'b0;
`ifdef TEST_PATTERN_EN
  logic pat_sel = 1'b0;
`endif
  logic [18:0] addrb;
  logic [11:0] doutb = 12'h000;
  logic [3:0] vga_r, vga_g, vga_b;
  logic vga_hs, vga_vs, frame_start, scanning;
  logic [11:0] mem [0:PIX-1];
  logic [11:0] rgb;
  int n, n_checks, n_fail;
  bit sparse;
  assign rgb = {vga_r, vga_g, vga_b};
  always #5 clk = ~clk;
  always @(posedge clk) doutb <= mem[addrb[6:0]];
  fb_scanout #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_ACTIVE(8),  .V_FP(1), .V_SYNC(2), .V_BP(1),
    .ADDR_W(19),   .DATA_W(12)
  ) dut (
    .clk(clk), .rstn(rstn), .pix_en(pix_en), .en(en),
`ifdef TEST_PATTERN_EN
    .pat_sel(pat_sel),
`endif
    .addrb(addrb), .doutb(doutb),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hs(vga_hs), .vga_vs(vga_vs),
    .frame_start(frame_start), .scanning(scanning)
  );
  // Expected address of counter position p (p = ticks since reset release).
  function automatic int exp_addr(int p);
    int x = p % HT;
    int y = (p / HT) % VT;
    if (y >= VA) return 0;
    if (x < HA) return y * HA + x;
    return ((y + 1) * HA) % PIX;
  endfunction
  // hsync low for x 18..21, vsync low for lines 9..10; p<0 is the reset value.
  function automatic logic exp_hs(int p);
    int x = p % HT;
    return p < 0 || !(x >= 18 && x < 22);
  endfunction
  function automatic logic exp_vs(int p);
    int y = (p / HT) % VT;
    return p < 0 || !(y >= 9 && y < 11);
  endfunction
  function automatic logic [11:0] exp_pix(int p);
    if (p < 0 || p % HT >= HA || (p / HT) % VT >= VA) return 12'h000;
    return mem[exp_addr(p)];
  endfunction
  task automatic step();
    if (sparse) begin
      pix_en = 1'b0;
      repeat (3) @(posedge clk);
      #1;
    end
    pix_en = 1'b1;
    @(posedge clk);
    #1;
    if (sparse) pix_en = 1'b0;
    n++;
  endtask
  task automatic do_reset();
    rstn = 1'b0;
    pix_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    n = 0;
  endtask
  task automatic test_reset();
    for (int i = 0; i < PIX; i++) mem[i] = 12'(i * 3 + 7);
    mem[0] = 12'h111;
    mem[5] = 12'hABC;
    mem[16] = 12'h123;
    mem[127] = 12'hFED;
    rstn = 1'b0;
    pix_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (addrb !== 19'd0) begin n_fail++; $display("FAIL reset_addrb: got %0d expected 0", addrb); end
    n_checks++; if (rgb !== 12'h000) begin n_fail++; $display("FAIL reset_rgb: got %h expected 000", rgb); end
    n_checks++; if (vga_hs !== 1'b1) begin n_fail++; $display("FAIL reset_hs: got %b expected 1", vga_hs); end
    n_checks++; if (vga_vs !== 1'b1) begin n_fail++; $display("FAIL reset_vs: got %b expected 1", vga_vs); end
    n_checks++; if (frame_start !== 1'b0) begin n_fail++; $display("FAIL reset_fs: got %b expected 0", frame_start); end
    n_checks++; if (scanning !== 1'b0) begin n_fail++; $display("FAIL reset_scan: got %b expected 0", scanning); end
    pix_en = 1'b0;
  endtask
  task automatic test_timing();
    int hs_low = 0, vs_low = 0, first_hs = -1;
    sparse = 0;
    en = 1'b1;
    do_reset();
    repeat (FT + 2) begin
      step();
      n_checks++; if (addrb !== 19'(exp_addr(n))) begin n_fail++; $display("FAIL addr n=%0d: got %0d expected %0d", n, addrb, exp_addr(n)); end
      n_checks++; if (frame_start !== ((n - 1) % FT == 0)) begin n_fail++; $display("FAIL frame_start n=%0d: got %b", n, frame_start); end
      n_checks++; if (vga_hs !== exp_hs(n - 2)) begin n_fail++; $display("FAIL hs n=%0d: got %b expected %b", n, vga_hs, exp_hs(n - 2)); end
      n_checks++; if (vga_vs !== exp_vs(n - 2)) begin n_fail++; $display("FAIL vs n=%0d: got %b expected %b", n, vga_vs, exp_vs(n - 2)); end
      if (n >= 2 && n <= FT + 1) begin
        if (!vga_hs) hs_low++;
        if (!vga_vs) vs_low++;
        if (!vga_hs && first_hs < 0) first_hs = n;
      end
      if (n == 183) begin
        n_checks++; if (addrb !== 19'd127) begin n_fail++; $display("FAIL last_addr: got %0d expected 127", addrb); end
      end
      if (n == 184) begin
        n_checks++; if (addrb !== 19'd0) begin n_fail++; $display("FAIL wrap_addr: got %0d expected 0", addrb); end
      end
    end
    n_checks++; if (first_hs !== 20) begin n_fail++; $display("FAIL hs_start: got %0d expected 20", first_hs); end
    n_checks++; if (hs_low !== 48) begin n_fail++; $display("FAIL hs_low_count: got %0d expected 48", hs_low); end
    n_checks++; if (vs_low !== 48) begin n_fail++; $display("FAIL vs_low_count: got %0d expected 48", vs_low); end
  endtask
  task automatic test_data();
    sparse = 0;
    en = 1'b1;
    do_reset();
    repeat (FT + 8) begin
      step();
      n_checks++; if (rgb !== exp_pix(n - 2)) begin n_fail++; $display("FAIL pix n=%0d: got %h expected %h", n, rgb, exp_pix(n - 2)); end
      if (n == 2) begin
        n_checks++; if (rgb !== 12'h111) begin n_fail++; $display("FAIL pix_x0y0: got %h expected 111", rgb); end
      end
      if (n == 7) begin
        n_checks++; if (vga_r !== 4'hA || vga_g !== 4'hB || vga_b !== 4'hC) begin n_fail++; $display("FAIL pix_x5y0: got %h expected abc", rgb); end
      end
      if (n == 20) begin
        n_checks++; if (rgb !== 12'h000) begin n_fail++; $display("FAIL pix_blank: got %h expected 000", rgb); end
      end
      if (n == 26) begin
        n_checks++; if (rgb !== 12'h123) begin n_fail++; $display("FAIL pix_x0y1: got %h expected 123", rgb); end
      end
      if (n == 185) begin
        n_checks++; if (rgb !== 12'hFED) begin n_fail++; $display("FAIL pix_last: got %h expected fed", rgb); end
      end
      if (n == 290) begin
        n_checks++; if (rgb !== 12'h111) begin n_fail++; $display("FAIL pix_frame2: got %h expected 111", rgb); end
      end
    end
  endtask
  task automatic test_enable();
    int cnt = 0;
    sparse = 0;
    en = 1'b1;
    do_reset();
    repeat (2 * FT + 8) begin
      step();
      if (n >= 290 && n <= 577 && rgb !== 12'h000) cnt++;
      if (n == 1 || n == 287 || n == 577) begin
        n_checks++; if (scanning !== 1'b1) begin n_fail++; $display("FAIL en_scan_on n=%0d: got %b expected 1", n, scanning); end
      end
      if (n == 288 || n == 289 || n == 576) begin
        n_checks++; if (scanning !== 1'b0) begin n_fail++; $display("FAIL en_scan_off n=%0d: got %b expected 0", n, scanning); end
      end
      if (n == 289 || n == 577) begin
        n_checks++; if (frame_start !== 1'b1) begin n_fail++; $display("FAIL en_frame_start n=%0d: got %b expected 1", n, frame_start); end
      end
      if (n == 185) begin
        n_checks++; if (rgb !== 12'hFED) begin n_fail++; $display("FAIL en_live: got %h expected fed", rgb); end
      end
      if (n == 578) begin
        n_checks++; if (rgb !== 12'h111) begin n_fail++; $display("FAIL en_resume0: got %h expected 111", rgb); end
      end
      if (n == 583) begin
        n_checks++; if (rgb !== 12'hABC) begin n_fail++; $display("FAIL en_resume5: got %h expected abc", rgb); end
      end
      if (n == 48) en = 1'b0;
      if (n == 300) en = 1'b1;
    end
    n_checks++; if (cnt !== 0) begin n_fail++; $display("FAIL en_idle_frame: got %0d nonzero pixels expected 0", cnt); end
  endtask
  task automatic test_sparse_reset();
    sparse = 1;
    en = 1'b1;
    do_reset();
    for (int pass = 0; pass < 2; pass++) begin
      repeat (pass == 0 ? 21 : 26) begin
        step();
        n_checks++; if (rgb !== exp_pix(n - 2)) begin n_fail++; $display("FAIL sparse_pix n=%0d: got %h expected %h", n, rgb, exp_pix(n - 2)); end
        n_checks++; if (addrb !== 19'(exp_addr(n))) begin n_fail++; $display("FAIL sparse_addr n=%0d: got %0d expected %0d", n, addrb, exp_addr(n)); end
        if (n == 1) begin
          n_checks++; if (frame_start !== 1'b1) begin n_fail++; $display("FAIL sparse_fs_tick: got %b expected 1", frame_start); end
          @(posedge clk);
          #1;
          n_checks++; if (frame_start !== 1'b0) begin n_fail++; $display("FAIL sparse_fs_idle: got %b expected 0", frame_start); end
          n_checks++; if (addrb !== 19'd1) begin n_fail++; $display("FAIL sparse_hold: got %0d expected 1", addrb); end
        end
        if (n == 7) begin
          n_checks++; if (rgb !== 12'hABC) begin n_fail++; $display("FAIL sparse_x5: got %h expected abc", rgb); end
        end
      end
      if (pass == 0) begin
        n_checks++; if (vga_hs !== 1'b0) begin n_fail++; $display("FAIL sparse_hs_low: got %b expected 0", vga_hs); end
      end
      rstn = 1'b0;
      #1;
      n_checks++; if (vga_hs !== 1'b1 || vga_vs !== 1'b1) begin n_fail++; $display("FAIL midrst_sync: got hs=%b vs=%b expected 1 1", vga_hs, vga_vs); end
      n_checks++; if (rgb !== 12'h000) begin n_fail++; $display("FAIL midrst_rgb: got %h expected 000", rgb); end
      n_checks++; if (addrb !== 19'd0) begin n_fail++; $display("FAIL midrst_addr: got %0d expected 0", addrb); end
      n_checks++; if (scanning !== 1'b0) begin n_fail++; $display("FAIL midrst_scan: got %b expected 0", scanning); end
      do_reset();
    end
    sparse = 0;
  endtask
`ifdef TEST_PATTERN_EN
  task automatic test_pattern();
    sparse = 0;
    en = 1'b1;
    pat_sel = 1'b1;
    do_reset();
    repeat (17) begin
      step();
      if (n == 2) begin
        n_checks++; if (rgb !== 12'h000) begin n_fail++; $display("FAIL pat_bar0: got %h expected 000", rgb); end
      end
      if (n == 5) begin
        n_checks++; if (rgb !== 12'h00F) begin n_fail++; $display("FAIL pat_bar1: got %h expected 00f", rgb); end
        n_checks++; if (addrb !== 19'd5) begin n_fail++; $display("FAIL pat_addr: got %0d expected 5", addrb); end
      end
      if (n == 17) begin
        n_checks++; if (rgb !== 12'hFFF) begin n_fail++; $display("FAIL pat_bar7: got %h expected fff", rgb); end
      end
    end
    pat_sel = 1'b0;
  endtask
`endif
  initial begin
    n_checks = 0;
    n_fail = 0;
    sparse = 0;
    test_reset();
    test_timing();
    test_data();
    test_enable();
    test_sparse_reset();
`ifdef TEST_PATTERN_EN
    test_pattern();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
